// File: rtl/demux_t_s_b.sv
// demux_t_s_b: time-slotted serial-to-parallel demultiplexer.
// While select_line is low, each aclk captures one x word into the next
// shadow slot, wrapping after the last slot. The first cycle that samples
// select_line high copies every slot into y at once. On that same edge it
// raises a one-cycle frame_valid, short_frame or overrun flag as applicable.
module demux_t_s_b #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_OUTPUTS       = GAMMA_CYCLE_WIDTH,
  parameter int BUS_WIDTH         = 8
) (
  input  logic                                  aclk,
  input  logic                                  grst,
  input  logic [BUS_WIDTH-1:0]                  x,
  input  logic                                  select_line,
  output logic [NUM_OUTPUTS-1:0][BUS_WIDTH-1:0] y,
  output logic                                  frame_valid,
  output logic                                  short_frame,
  output logic                                  overrun,
  output logic [$clog2(NUM_OUTPUTS)-1:0]        slot
);

  localparam int SLOT_W = $clog2(NUM_OUTPUTS);
  // Two extra bits let the count reach NUM_OUTPUTS+1, which marks "too many".
  localparam int CNT_W  = $clog2(NUM_OUTPUTS) + 2;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_OUTPUTS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(NUM_OUTPUTS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(NUM_OUTPUTS + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [SLOT_W-1:0]    slot_reg;
  logic [CNT_W-1:0]     wr_cnt_reg;
  logic                 ovf_reg;
  logic                 sel_q_reg;
  logic                 frame_valid_reg;
  logic                 short_frame_reg;
  logic                 overrun_reg;

  logic [BUS_WIDTH-1:0] shadow_reg [NUM_OUTPUTS];
  logic [BUS_WIDTH-1:0] y_reg      [NUM_OUTPUTS];

  logic                 capture;
  logic                 commit_edge;
  logic                 commit_frame;
  logic [SLOT_W-1:0]    slot_next;
  logic [CNT_W-1:0]     wr_cnt_next;

  // Capture and commit use opposite select_line levels, so they can never
  // both be active in the same cycle.
  assign capture      = ~select_line;
  assign commit_edge  = select_line & ~sel_q_reg;
  // A rising edge with nothing captured is an empty commit: y is left alone.
  assign commit_frame = commit_edge & (wr_cnt_reg != '0);

  // Next write slot wraps so that an overlong window overwrites the oldest words.
  always_comb begin
    slot_next = (slot_reg == SLOT_LAST) ? '0 : slot_reg + SLOT_W'(1);
  end

  // Write count saturates one past full; that value is enough to flag an overrun.
  always_comb begin
    wr_cnt_next = (wr_cnt_reg == CNT_SAT) ? wr_cnt_reg : wr_cnt_reg + CNT_ONE;
  end

  // Window bookkeeping: write pointer, write count, sticky overrun, select history.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      slot_reg   <= '0;
      wr_cnt_reg <= '0;
      ovf_reg    <= 1'b0;
      sel_q_reg  <= 1'b0;
    end else begin
      sel_q_reg <= select_line;
      if (capture) begin
        slot_reg   <= slot_next;
        wr_cnt_reg <= wr_cnt_next;
        if (wr_cnt_reg >= CNT_FULL) begin
          ovf_reg <= 1'b1;
        end
      end else if (commit_edge) begin
        slot_reg   <= '0;
        wr_cnt_reg <= '0;
        ovf_reg    <= 1'b0;
      end
    end
  end

  // Status pulses: recomputed every cycle, so they drop back to 0 on the next edge.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      frame_valid_reg <= 1'b0;
      short_frame_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_valid_reg <= commit_frame;
      short_frame_reg <= commit_edge & (wr_cnt_reg < CNT_FULL);
      overrun_reg     <= commit_frame & ovf_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_slot
      logic slot_hit;

      assign slot_hit = capture && (slot_reg == SLOT_W'(gi));

      // Shadow slot: takes x when addressed and is cleared after each commit,
      // so slots left unwritten in the next window read back as 0.
      always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
          shadow_reg[gi] <= '0;
        end else if (slot_hit) begin
          shadow_reg[gi] <= x;
        end else if (commit_frame) begin
          shadow_reg[gi] <= '0;
        end
      end

      // Output word: loads the shadow slot only on a non-empty commit.
      always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
          y_reg[gi] <= '0;
        end else if (commit_frame) begin
          y_reg[gi] <= shadow_reg[gi];
        end
      end

      assign y[gi] = y_reg[gi];
    end
  endgenerate

  assign frame_valid = frame_valid_reg;
  assign short_frame = short_frame_reg;
  assign overrun     = overrun_reg;
  assign slot        = slot_reg;

endmodule

// File: tb/tb_demux_t_s_b.sv
// Testbench for demux_t_s_b. A reference model keeps each window's words in a queue.
// It derives the expected frame from the slot = (index mod NUM_OUTPUTS) rule,
// and short/overrun from the number of words written.
module tb_demux_t_s_b;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic                  aclk = 1'b0;
  logic                  grst;
  logic [W-1:0]          x;
  logic                  select_line;
  logic [N-1:0][W-1:0]   y;
  logic                  frame_valid;
  logic                  short_frame;
  logic                  overrun;
  logic [SW-1:0]         slot;

  int total = 0;
  int bad   = 0;

  logic [N-1:0][W-1:0]   exp_y;
  logic [W-1:0]          wq [$];

  demux_t_s_b #(
    .GAMMA_CYCLE_WIDTH (N),
    .NUM_OUTPUTS       (N),
    .BUS_WIDTH         (W)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .x           (x),
    .select_line (select_line),
    .y           (y),
    .frame_valid (frame_valid),
    .short_frame (short_frame),
    .overrun     (overrun),
    .slot        (slot)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Capture the words in wq, commit them, then hold select_line high.
  task automatic run_window(input string name, input int hold_cycles);
    int n;
    int fv_seen;
    logic [N-1:0][W-1:0] model;
    logic exp_short;
    logic exp_ovr;
    n = wq.size();
    model = '0;
    for (int k = 0; k < n; k++) model[k % N] = wq[k];
    exp_short = (n < N);
    exp_ovr   = (n > N);

    for (int k = 0; k < n; k++) begin
      select_line = 1'b0;
      x = wq[k];
      tick();
      total++;
      if (slot !== SW'((k + 1) % N)) begin
        bad++;
        $display("FAIL %s slot after write %0d: got %0d want %0d", name, k, slot, (k + 1) % N);
      end
    end
    total++;
    if (frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun !== 1'b0 || y !== exp_y) begin
      bad++;
      $display("FAIL %s window_hold: fv=%b sf=%b ov=%b y=%h want 0 0 0 y=%h",
               name, frame_valid, short_frame, overrun, y, exp_y);
    end

    select_line = 1'b1;
    x = W'($urandom);
    tick();
    exp_y = model;
    total++;
    if (frame_valid !== 1'b1 || short_frame !== exp_short || overrun !== exp_ovr) begin
      bad++;
      $display("FAIL %s commit_flags: fv=%b sf=%b ov=%b want 1 %b %b",
               name, frame_valid, short_frame, overrun, exp_short, exp_ovr);
    end
    total++;
    if (y !== exp_y) begin
      bad++;
      $display("FAIL %s commit_y: got %h want %h", name, y, exp_y);
    end
    total++;
    if (slot !== '0) begin
      bad++;
      $display("FAIL %s commit_slot: got %0d want 0", name, slot);
    end

    fv_seen = (frame_valid === 1'b1) ? 1 : 0;
    for (int c = 0; c < hold_cycles; c++) begin
      tick();
      if (frame_valid === 1'b1) fv_seen++;
      total++;
      if (frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun !== 1'b0 || y !== exp_y) begin
        bad++;
        $display("FAIL %s hold_cycle %0d: fv=%b sf=%b ov=%b y=%h want 0 0 0 y=%h",
                 name, c, frame_valid, short_frame, overrun, y, exp_y);
      end
    end
    if (hold_cycles > 0) begin
      total++;
      if (fv_seen != 1) begin
        bad++;
        $display("FAIL %s frame_valid_count: got %0d want 1", name, fv_seen);
      end
    end
    $display("frame %s len=%0d short=%b overrun=%b hold=%0d y=%h", name, n, exp_short, exp_ovr, hold_cycles, exp_y);
  endtask

  task automatic test_reset();
    grst = 1'b1;
    select_line = 1'b1;
    x = '0;
    exp_y = '0;
    tick();
    tick();
    total++;
    if (y !== '0 || frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun !== 1'b0 || slot !== '0) begin
      bad++;
      $display("FAIL reset_state: y=%h fv=%b sf=%b ov=%b slot=%0d want all 0",
               y, frame_valid, short_frame, overrun, slot);
    end
    $display("reset applied, outputs cleared");
  endtask

  // select_line already high when reset releases: one short_frame pulse, no frame.
  task automatic test_empty_commit();
    int sf_seen;
    int fv_seen;
    grst = 1'b0;
    tick();
    total++;
    if (short_frame !== 1'b1 || frame_valid !== 1'b0 || overrun !== 1'b0 || y !== '0) begin
      bad++;
      $display("FAIL empty_commit: sf=%b fv=%b ov=%b y=%h want 1 0 0 y=0",
               short_frame, frame_valid, overrun, y);
    end
    sf_seen = 1;
    fv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (short_frame === 1'b1) sf_seen++;
      if (frame_valid === 1'b1) fv_seen++;
    end
    total++;
    if (sf_seen != 1 || fv_seen != 0 || y !== '0 || slot !== '0) begin
      bad++;
      $display("FAIL empty_hold: sf_pulses=%0d fv_pulses=%0d y=%h slot=%0d want 1 0 0 0",
               sf_seen, fv_seen, y, slot);
    end
    $display("empty commit: short_frame pulses=%0d frame_valid pulses=%0d", sf_seen, fv_seen);
  endtask

  task automatic test_full_frame();
    wq.delete();
    for (int k = 0; k < N; k++) wq.push_back(W'(3 * k + 1));
    run_window("full", 20);
  endtask

  task automatic test_short_frame();
    wq.delete();
    for (int k = 0; k < 5; k++) wq.push_back(W'(8'hA0 + k));
    run_window("short", 2);
  endtask

  task automatic test_overrun();
    wq.delete();
    for (int k = 0; k < 18; k++) wq.push_back(W'(k));
    run_window("overrun", 2);
  endtask

  task automatic test_single_and_boundaries();
    wq.delete();
    wq.push_back(W'(8'h5C));
    run_window("single", 1);
    wq.delete();
    for (int k = 0; k < N - 1; k++) wq.push_back(W'($urandom));
    run_window("n_minus_1", 1);
    wq.delete();
    for (int k = 0; k < N + 1; k++) wq.push_back(W'($urandom));
    run_window("n_plus_1", 1);
    wq.delete();
    for (int k = 0; k < 3 * N + 5; k++) wq.push_back(W'($urandom));
    run_window("saturate", 0);
  endtask

  task automatic test_reset_mid_window();
    wq.delete();
    for (int k = 0; k < N; k++) wq.push_back(W'($urandom_range(1, 255)));
    run_window("pre_reset", 1);
    for (int k = 0; k < 7; k++) begin
      select_line = 1'b0;
      x = W'($urandom);
      tick();
    end
    #3;
    grst = 1'b1;
    #1;
    exp_y = '0;
    total++;
    if (y !== '0 || frame_valid !== 1'b0 || short_frame !== 1'b0 || overrun !== 1'b0 || slot !== '0) begin
      bad++;
      $display("FAIL async_reset: y=%h fv=%b sf=%b ov=%b slot=%0d want all 0",
               y, frame_valid, short_frame, overrun, slot);
    end
    tick();
    grst = 1'b0;
    total++;
    if (frame_valid !== 1'b0 || short_frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_pulse: fv=%b sf=%b want 0 0", frame_valid, short_frame);
    end
    $display("reset mid-window after 7 writes");
    wq.delete();
    for (int k = 0; k < N; k++) wq.push_back(W'($urandom));
    run_window("post_reset", 2);
  endtask

  task automatic test_random();
    int len;
    int hold;
    for (int f = 0; f < 25; f++) begin
      len  = $urandom_range(1, 2 * N + 8);
      hold = $urandom_range(0, 3);
      wq.delete();
      for (int k = 0; k < len; k++) wq.push_back(W'($urandom));
      run_window($sformatf("rand%0d", f), hold);
    end
  endtask

  initial begin
    test_reset();
    test_empty_commit();
    test_full_frame();
    test_short_frame();
    test_overrun();
    test_single_and_boundaries();
    test_reset_mid_window();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
